// File: rtl/wash_pkg.sv
// rtl/wash_pkg.sv - shared types, duration table and display codes for wash_ctrl
package wash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WASH,
    ST_RINSE,
    ST_SPIN,
    ST_DONE
  } state_e;

  // Phase durations in seconds: rows by mode, columns wash / rinse / spin
  localparam logic [6:0] DUR_TBL [4][3] = '{
    '{7'd0,   7'd0,  7'd30},
    '{7'd60,  7'd30, 7'd30},
    '{7'd90,  7'd45, 7'd30},
    '{7'd120, 7'd60, 7'd60}
  };

  localparam logic [3:0] BLANK_CODE = 4'd11;
  localparam logic [3:0] DIG_WASH   = 4'd1;
  localparam logic [3:0] DIG_RINSE  = 4'd2;
  localparam logic [3:0] DIG_SPIN   = 4'd3;
  localparam logic [3:0] DIG_DONE   = 4'd0;

  localparam logic [7:0] LED_IDLE  = 8'h01;
  localparam logic [7:0] LED_WASH  = 8'h02;
  localparam logic [7:0] LED_RINSE = 8'h04;
  localparam logic [7:0] LED_SPIN  = 8'h08;
  localparam logic [7:0] LED_DONE  = 8'h10;
  localparam logic [7:0] LED_PAUSE = 8'h20;

  function automatic logic [6:0] phase_dur(input logic [1:0] m, input state_e ph);
    logic [6:0] d;
    case (ph)
      ST_WASH:  d = DUR_TBL[m][0];
      ST_RINSE: d = DUR_TBL[m][1];
      ST_SPIN:  d = DUR_TBL[m][2];
      default:  d = 7'd0;
    endcase
    return d;
  endfunction

  // Next phase with a nonzero duration; SPIN always has one, so it is the fallback
  function automatic state_e next_phase(input logic [1:0] m, input state_e cur);
    state_e n;
    case (cur)
      ST_IDLE:  n = (phase_dur(m, ST_WASH) != 7'd0)  ? ST_WASH :
                    (phase_dur(m, ST_RINSE) != 7'd0) ? ST_RINSE : ST_SPIN;
      ST_WASH:  n = (phase_dur(m, ST_RINSE) != 7'd0) ? ST_RINSE : ST_SPIN;
      ST_RINSE: n = ST_SPIN;
      default:  n = ST_DONE;
    endcase
    return n;
  endfunction

  function automatic logic [8:0] total_dur(input logic [1:0] m);
    return 9'(DUR_TBL[m][0]) + 9'(DUR_TBL[m][1]) + 9'(DUR_TBL[m][2]);
  endfunction

endpackage

// File: rtl/sec_tick.sv
// rtl/sec_tick.sv - 1-second prescaler, freezes when en_i is low
module sec_tick #(
  parameter int CLK_HZ = 100000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count 0..CLK_HZ-1 while enabled; clear wins, disabled holds the value
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/wash_ctrl.sv
// rtl/wash_ctrl.sv - wash programme sequencer; WASH_DOOR_LOCK_EN adds door_open_i/lock_o
module wash_ctrl
  import wash_pkg::*;
#(
  parameter int         CLK_HZ = 100000000,
  parameter logic [3:0] BLANK  = BLANK_CODE
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       on_i,
  input  logic       start_i,
  input  logic [1:0] mode_i,
  input  logic       pause_pos_i,
`ifdef WASH_DOOR_LOCK_EN
  input  logic       door_open_i,
  output logic       lock_o,
`endif
  output logic       busy_o,
  output logic       done_o,
  output logic       motor_o,
  output logic       drain_o,
  output logic [3:0] dig3_o,
  output logic [3:0] dig2_o,
  output logic [3:0] dig1_o,
  output logic [3:0] dig0_o,
  output logic [7:0] st_light_o
);

  state_e      state_q, state_d, nxt;
  logic        paused_q, paused_d;
  logic [1:0]  mode_q, mode_d;
  logic [6:0]  phase_q, phase_d;
  logic [8:0]  total_q, total_d;
  logic [1:0]  done_cnt_q, done_cnt_d;
  logic        done_q, done_d;
  logic [11:0] bcd_q, bcd_d;
  logic        in_phase, tick, door;

`ifdef WASH_DOOR_LOCK_EN
  assign door   = door_open_i;
  assign lock_o = busy_o;
`else
  assign door = 1'b0;
`endif

  assign in_phase = (state_q == ST_WASH) || (state_q == ST_RINSE) || (state_q == ST_SPIN);

  sec_tick #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   ((in_phase && !paused_q) || (state_q == ST_DONE)),
    .clr_i  (state_q == ST_IDLE),
    .tick_o (tick)
  );

  // State, timers and display registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      paused_q   <= 1'b0;
      mode_q     <= 2'd0;
      phase_q    <= 7'd0;
      total_q    <= 9'd0;
      done_cnt_q <= 2'd0;
      done_q     <= 1'b0;
      bcd_q      <= 12'd0;
    end else begin
      state_q    <= state_d;
      paused_q   <= paused_d;
      mode_q     <= mode_d;
      phase_q    <= phase_d;
      total_q    <= total_d;
      done_cnt_q <= done_cnt_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
    end
  end

  // Next state: power-off, then tick-driven countdown, then pause toggling
  always_comb begin
    state_d    = state_q;
    paused_d   = paused_q;
    mode_d     = mode_q;
    phase_d    = phase_q;
    total_d    = total_q;
    done_cnt_d = done_cnt_q;
    nxt        = next_phase(mode_q, state_q);
    if (!on_i) begin
      state_d    = ST_IDLE;
      paused_d   = 1'b0;
      phase_d    = 7'd0;
      total_d    = 9'd0;
      done_cnt_d = 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i && !door) begin
            nxt      = next_phase(mode_i, ST_IDLE);
            state_d  = nxt;
            mode_d   = mode_i;
            phase_d  = phase_dur(mode_i, nxt);
            total_d  = total_dur(mode_i);
            paused_d = 1'b0;
          end
        end
        ST_WASH, ST_RINSE, ST_SPIN: begin
          if (tick) begin
            phase_d = phase_q - 7'd1;
            total_d = total_q - 9'd1;
            if (phase_q == 7'd1) begin
              state_d    = nxt;
              phase_d    = phase_dur(mode_q, nxt);
              done_cnt_d = 2'd0;
            end
          end
          // A pause can never carry into DONE, whose countdown ignores it
          if (state_d == ST_DONE)  paused_d = 1'b0;
          else if (door)           paused_d = 1'b1;
          else if (pause_pos_i)    paused_d = !paused_q;
        end
        ST_DONE: begin
          if (tick) begin
            if (done_cnt_q == 2'd2) state_d = ST_IDLE;
            else                    done_cnt_d = done_cnt_q + 2'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    bcd_d  = {4'(total_q / 9'd100), 4'((total_q % 9'd100) / 9'd10), 4'(total_q % 9'd10)};
  end

  // Outputs decoded from the registered state
  always_comb begin
    busy_o     = in_phase;
    motor_o    = in_phase && !paused_q;
    drain_o    = (state_q == ST_SPIN) && !paused_q;
    done_o     = done_q;
    dig2_o     = bcd_q[11:8];
    dig1_o     = bcd_q[7:4];
    dig0_o     = bcd_q[3:0];
    dig3_o     = BLANK;
    st_light_o = LED_IDLE;
    case (state_q)
      ST_WASH:  begin dig3_o = DIG_WASH;  st_light_o = LED_WASH;  end
      ST_RINSE: begin dig3_o = DIG_RINSE; st_light_o = LED_RINSE; end
      ST_SPIN:  begin dig3_o = DIG_SPIN;  st_light_o = LED_SPIN;  end
      ST_DONE: begin
        dig3_o     = DIG_DONE;
        dig2_o     = 4'd0;
        dig1_o     = 4'd0;
        dig0_o     = 4'd0;
        st_light_o = LED_DONE;
      end
      default: begin
        dig2_o = BLANK;
        dig1_o = BLANK;
        dig0_o = BLANK;
      end
    endcase
    if (paused_q) st_light_o = st_light_o | LED_PAUSE;
  end

endmodule

// File: tb/tb_wash_ctrl.sv
// tb/tb_wash_ctrl.sv - directed scoreboard bench for wash_ctrl (CLK_HZ=10)
module tb_wash_ctrl;

  localparam int         HZ = 10;
  localparam logic [3:0] BL = 4'd11;

  logic       clk = 1'b0;
  logic       rst, on, start, pause_pos;
  logic [1:0] mode;
  logic       busy, done, motor, drain;
  logic [3:0] dig3, dig2, dig1, dig0;
  logic [7:0] st_light;
`ifdef WASH_DOOR_LOCK_EN
  logic       door_open, lock;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  wash_ctrl #(.CLK_HZ(HZ), .BLANK(BL)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .on_i        (on),
    .start_i     (start),
    .mode_i      (mode),
    .pause_pos_i (pause_pos),
`ifdef WASH_DOOR_LOCK_EN
    .door_open_i (door_open),
    .lock_o      (lock),
`endif
    .busy_o      (busy),
    .done_o      (done),
    .motor_o     (motor),
    .drain_o     (drain),
    .dig3_o      (dig3),
    .dig2_o      (dig2),
    .dig1_o      (dig1),
    .dig0_o      (dig0),
    .st_light_o  (st_light)
  );

  typedef struct {
    int         at;
    logic [3:0] d3;
    string      tag;
  } ev_t;

  ev_t sb[$];
  int  n_total = 0;
  int  n_pass  = 0;
  int  n_fail  = 0;
  int  t0      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [1:0] m);
    mode  = m;
    start = 1'b1;
    step(1);
    start = 1'b0;
    t0    = cyc;
  endtask

  task automatic pulse_pause();
    pause_pos = 1'b1;
    step(1);
    pause_pos = 1'b0;
  endtask

  task automatic push_ev(input int at, input logic [3:0] d3, input string tag);
    ev_t e;
    e.at  = at;
    e.d3  = d3;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Pop the next expected phase change and wait (bounded) for dig3 to move
  task automatic expect_ev();
    ev_t        e;
    logic [3:0] prev;
    int         w;
    e    = sb.pop_front();
    prev = dig3;
    w    = 0;
    while (dig3 === prev && w < 5000) begin
      step(1);
      w++;
    end
    chk({e.tag, "_time"}, cyc - t0, e.at);
    chk({e.tag, "_dig3"}, 32'(dig3), 32'(e.d3));
  endtask

  task automatic chk_digits(input string tag, input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
    chk({tag, "_d2"}, 32'(dig2), 32'(h));
    chk({tag, "_d1"}, 32'(dig1), 32'(t));
    chk({tag, "_d0"}, 32'(dig0), 32'(u));
  endtask

  initial begin
    rst = 1'b1; on = 1'b1; start = 1'b0; pause_pos = 1'b0; mode = 2'd0;
`ifdef WASH_DOOR_LOCK_EN
    door_open = 1'b0;
`endif
    step(2);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_motor", 32'(motor), 0);
    chk("rst_drain", 32'(drain), 0);
    chk("rst_dig3", 32'(dig3), 32'(BL));
    chk_digits("rst", BL, BL, BL);
    chk("rst_light", 32'(st_light), 32'h01);

    // mode 01: 60/30/30 seconds
    pulse_start(2'd1);
    chk("m1_dig3", 32'(dig3), 1);
    chk("m1_motor", 32'(motor), 1);
    chk("m1_busy", 32'(busy), 1);
    chk("m1_light", 32'(st_light), 32'h02);
    step(1);
    chk_digits("m1_start", 4'd1, 4'd2, 4'd0);
    push_ev(600, 4'd2, "m1_rinse");
    push_ev(900, 4'd3, "m1_spin");
    push_ev(1200, 4'd0, "m1_done");
    push_ev(1230, BL, "m1_idle");
    expect_ev();
    mode = 2'd3; start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    chk("m1_rinse_start_ign", 32'(dig3), 2);
    chk_digits("m1_rinse", 4'd0, 4'd6, 4'd0);
    chk("m1_rinse_drain", 32'(drain), 0);
    expect_ev();
    chk("m1_spin_drain", 32'(drain), 1);
    expect_ev();
    chk("m1_done_pulse", 32'(done), 1);
    chk("m1_done_light", 32'(st_light), 32'h10);
    chk("m1_done_busy", 32'(busy), 0);
    chk_digits("m1_done", 4'd0, 4'd0, 4'd0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("m1_done_pulse_end", 32'(done), 0);
    chk("m1_done_start_ign", 32'(dig3), 0);
    expect_ev();
    chk("m1_idle_light", 32'(st_light), 32'h01);
    chk("m1_idle_d0", 32'(dig0), 32'(BL));

    // mode 00: spin only
    pulse_start(2'd0);
    chk("m0_dig3", 32'(dig3), 3);
    chk("m0_drain", 32'(drain), 1);
    chk("m0_light", 32'(st_light), 32'h08);
    step(1);
    chk_digits("m0_start", 4'd0, 4'd3, 4'd0);
    push_ev(300, 4'd0, "m0_done");
    push_ev(330, BL, "m0_idle");
    expect_ev();
    chk("m0_done_pulse", 32'(done), 1);
    expect_ev();

    // pause in IDLE is ignored, then mode 11 with a 200-cycle pause
    pulse_pause();
    chk("idle_pause_ign", 32'(st_light), 32'h01);
    pulse_start(2'd3);
    step(54);
    pulse_pause();
    chk("m3_pause_motor", 32'(motor), 0);
    chk("m3_pause_light", 32'(st_light), 32'h22);
    chk("m3_pause_busy", 32'(busy), 1);
    chk_digits("m3_pause", 4'd2, 4'd3, 4'd5);
    step(100);
    chk_digits("m3_frozen", 4'd2, 4'd3, 4'd5);
    chk("m3_frozen_motor", 32'(motor), 0);
    step(99);
    pulse_pause();
    chk("m3_resume_motor", 32'(motor), 1);
    chk("m3_resume_light", 32'(st_light), 32'h02);
    step(6);
    chk_digits("m3_resume", 4'd2, 4'd3, 4'd4);
    push_ev(1400, 4'd2, "m3_rinse");
    push_ev(2000, 4'd3, "m3_spin");
    push_ev(2600, 4'd0, "m3_done");
    push_ev(2630, BL, "m3_idle");
    expect_ev();
    expect_ev();
    expect_ev();
    expect_ev();

    // power off mid-WASH
    pulse_start(2'd2);
    chk("m2_dig3", 32'(dig3), 1);
    step(99);
    on = 1'b0;
    step(1);
    chk("off_dig3", 32'(dig3), 32'(BL));
    chk_digits("off", BL, BL, BL);
    chk("off_busy", 32'(busy), 0);
    chk("off_done", 32'(done), 0);
    chk("off_light", 32'(st_light), 32'h01);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("off_start_ign", 32'(dig3), 32'(BL));
    chk("off_no_done", 32'(done), 0);
    on = 1'b1;
    step(1);

    // reset mid-SPIN while paused
    pulse_start(2'd0);
    step(20);
    pulse_pause();
    chk("spin_pause_light", 32'(st_light), 32'h28);
    chk("spin_pause_drain", 32'(drain), 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst2_busy", 32'(busy), 0);
    chk("rst2_motor", 32'(motor), 0);
    chk("rst2_dig3", 32'(dig3), 32'(BL));
    chk("rst2_d1", 32'(dig1), 32'(BL));
    chk("rst2_light", 32'(st_light), 32'h01);
    pulse_start(2'd0);
    chk("rst2_restart_motor", 32'(motor), 1);
    chk("rst2_restart_drain", 32'(drain), 1);
    on = 1'b0;
    step(1);
    on = 1'b1;
    step(1);

`ifdef WASH_DOOR_LOCK_EN
    door_open = 1'b1;
    pulse_start(2'd1);
    chk("door_start_ign", 32'(dig3), 32'(BL));
    door_open = 1'b0;
    pulse_start(2'd1);
    chk("door_run_dig3", 32'(dig3), 1);
    chk("door_lock", 32'(lock), 1);
    door_open = 1'b1;
    step(1);
    chk("door_paused_motor", 32'(motor), 0);
    chk("door_paused_light", 32'(st_light), 32'h22);
    pulse_pause();
    chk("door_pause_ign", 32'(motor), 0);
    door_open = 1'b0;
    step(1);
    chk("door_closed_still", 32'(motor), 0);
    pulse_pause();
    chk("door_resume", 32'(motor), 1);
    on = 1'b0;
    step(1);
    on = 1'b1;
    chk("door_unlock", 32'(lock), 0);
    step(1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wash_ctrl.md
Name: wash_ctrl

Overview:
- Downstream stage of the billing block. Consumes its one-cycle `next` pulse (payment accepted) together with the selected `mode`, then sequences the wash programme.
- Programme phases are WASH, RINSE and SPIN, counted down in 1-second ticks. Drives motor/drain outputs, the status LEDs, and four 4-bit digit codes for the existing 4-digit scanner (remaining time).

Parameters:
- CLK_HZ, 100000000, clock cycles per 1-second tick (bench uses 10).
- BLANK, 4'd11, digit code that turns a scanner digit off.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- on  in  1  power switch; 0 forces IDLE
- start  in  1  one-cycle pulse from billing `next`
- mode  in  2  00 spin-only, 01 small, 10 medium, 11 large
- pause_pos  in  1  one-cycle button pulse; toggles pause while running
- busy  out  1  high in WASH/RINSE/SPIN, including while paused
- done  out  1  one-cycle pulse on entry to DONE
- motor  out  1  high in WASH/RINSE/SPIN when not paused
- drain  out  1  high in SPIN when not paused
- dig3  out  4  phase code: 1 wash, 2 rinse, 3 spin, 0 done, BLANK idle
- dig2, dig1, dig0  out  4 each  BCD hundreds/tens/units of total remaining seconds
- st_light  out  8  one-hot state LEDs

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, paused=0, timers=0, busy/done/motor/drain=0, all digits BLANK, st_light=8'b00000001.
- States: IDLE, WASH, RINSE, SPIN, DONE.
- Phase durations in seconds, as (wash, rinse, spin):
  - mode 00: (0, 0, 30)
  - mode 01: (60, 30, 30)
  - mode 10: (90, 45, 30)
  - mode 11: (120, 60, 60)
  - Zero-length phases are skipped. Maximum total is 240 s, held in a 9-bit counter.
- IDLE:
  - start=1 and on=1 → next cycle enters the first nonzero phase.
  - At that entry: mode is latched, phase_sec and total_sec are loaded, and the prescaler is cleared.
  - start while busy or in DONE is ignored.
- Tick:
  - Prescaler counts 0..CLK_HZ-1 while running and not paused, and pulses tick on wrap. The first tick comes exactly CLK_HZ cycles after phase entry.
  - On each tick, phase_sec and total_sec decrement.
  - If phase_sec was 1, the same edge moves to the next nonzero phase and loads its duration. No idle cycle is inserted between phases.
  - SPIN expiry → DONE.
- Pause:
  - pause_pos while busy toggles paused. The prescaler freezes at its current value and resumes from it.
  - pause_pos in IDLE or DONE is ignored.
- DONE: done pulses on the entry cycle. The block holds DONE for 3 ticks (prescaler running), then goes to IDLE. No start is accepted in DONE.
- on=0: on the next edge the block goes to IDLE from any state, clears paused, and does not pulse done. on=0 also blocks start.
- Simultaneous events:
  - rst beats on, which beats tick, which beats pause_pos.
  - pause_pos on a tick edge: the tick is applied first, then paused is set.
- Display:
  - dig2..0 = BCD of total_sec, registered with 1-cycle latency from the counter.
  - Leading zeros are shown, not blanked.
  - DONE shows 0,0,0,0. IDLE shows all BLANK.
- st_light:
  - One-hot by state: IDLE 0x01, WASH 0x02, RINSE 0x04, SPIN 0x08, DONE 0x10.
  - Bit 5 is ORed in while paused.

Optional Feature:
- WASH_DOOR_LOCK_EN defined:
  - Adds input door_open and output lock; lock = busy.
  - door_open=1 while busy forces paused=1, and pause_pos cannot clear it until door_open=0.
  - start is ignored while door_open=1.
- Not defined: neither port exists, and pause is controlled only by pause_pos.

Decomposition:
- Package wash_pkg holds:
  - the state enum;
  - the 4×3 duration constant table indexed by mode;
  - the BLANK and phase digit codes;
  - the st_light codes.
- Sub-module sec_tick is the prescaler. It has clk, rst, en and clr inputs and a tick output, parameterised by CLK_HZ.
- The BCD split (constant divide by 100/10 on a 9-bit value) stays inline.

Test Plan:
- CLK_HZ=10, mode 01, start pulse:
  - next cycle: dig3=1, digits 1,2,0, motor=1;
  - WASH→RINSE after exactly 600 cycles, SPIN after 900, DONE after 1200;
  - done pulses 1 cycle; IDLE 30 cycles later.
- mode 00 start → enters SPIN directly with dig3=3, digits 0,3,0; drain=1; RINSE and WASH never visited.
- Mode 11 run:
  - pause_pos at cycle 55 → motor=0, st_light bit5=1, digits frozen for 200 cycles;
  - second pause_pos resumes, and the whole schedule shifts by exactly 200 cycles.
- start during RINSE and start in DONE → no change of state or timers.
- on=0 mid-WASH → IDLE next cycle, digits BLANK, no done pulse; rst=1 mid-SPIN → all reset values next cycle.
- With WASH_DOOR_LOCK_EN:
  - door_open=1 in WASH → paused, and pause_pos has no effect;
  - door_open=0 then pause_pos → resumes;
  - start with door open → ignored.
